// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register for the 16-bit microRISC core.
// Async reset and async flush both collapse the stage to a bubble.
module mem_wb_reg #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_to_reg,
    input  logic [DATA_W-1:0]     mem_alu_result,
    input  logic [DATA_W-1:0]     mem_read_data,
    input  logic [REG_ADDR_W-1:0] mem_write_reg,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [DATA_W-1:0]     wb_alu_result,
    output logic [DATA_W-1:0]     wb_read_data,
    output logic [REG_ADDR_W-1:0] wb_write_reg
);

    logic                  r_reg_write;
    logic                  r_mem_to_reg;
    logic [DATA_W-1:0]     r_alu_result;
    logic [DATA_W-1:0]     r_read_data;
    logic [REG_ADDR_W-1:0] r_write_reg;

    // flush is in the sensitivity list so a bubble appears mid-cycle
    always_ff @(posedge clk or negedge rst_n or posedge flush) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_result <= '0;
            r_read_data  <= '0;
            r_write_reg  <= '0;
        end else if (flush) begin
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_result <= '0;
            r_read_data  <= '0;
            r_write_reg  <= '0;
        end else begin
            r_reg_write  <= mem_reg_write;
            r_mem_to_reg <= mem_mem_to_reg;
            r_alu_result <= mem_alu_result;
            r_read_data  <= mem_read_data;
            r_write_reg  <= mem_write_reg;
        end
    end

    assign wb_reg_write  = r_reg_write;
    assign wb_mem_to_reg = r_mem_to_reg;
    assign wb_alu_result = r_alu_result;
    assign wb_read_data  = r_read_data;
    assign wb_write_reg  = r_write_reg;

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed self-checking bench for mem_wb_reg.
// Outputs are packed {rw, mtr, alu, rd, wr} and compared to hand values.
module tb_mem_wb_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        mem_reg_write;
    logic        mem_mem_to_reg;
    logic [15:0] mem_alu_result;
    logic [15:0] mem_read_data;
    logic [2:0]  mem_write_reg;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [15:0] wb_alu_result;
    logic [15:0] wb_read_data;
    logic [2:0]  wb_write_reg;

    logic [36:0] w_obs;
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_wb_reg #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_to_reg (mem_mem_to_reg),
        .mem_alu_result (mem_alu_result),
        .mem_read_data  (mem_read_data),
        .mem_write_reg  (mem_write_reg),
        .wb_reg_write   (wb_reg_write),
        .wb_mem_to_reg  (wb_mem_to_reg),
        .wb_alu_result  (wb_alu_result),
        .wb_read_data   (wb_read_data),
        .wb_write_reg   (wb_write_reg)
    );

    always #5 clk = ~clk;

    assign w_obs = {wb_reg_write, wb_mem_to_reg, wb_alu_result,
                    wb_read_data, wb_write_reg};

    task automatic chk(input string tag, input logic [36:0] got,
                       input logic [36:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mtr,
                         input logic [15:0] alu, input logic [15:0] rd,
                         input logic [2:0] wr);
        mem_reg_write  = rw;
        mem_mem_to_reg = mtr;
        mem_alu_result = alu;
        mem_read_data  = rd;
        mem_write_reg  = wr;
    endtask

    localparam logic [36:0] ZERO = 37'h0;
    localparam logic [36:0] VEC_A = {1'b1, 1'b1, 16'hABCD, 16'h1234, 3'b101};
    localparam logic [36:0] VEC_B = {1'b1, 1'b0, 16'h5A5A, 16'hC3C3, 3'b010};
    localparam logic [36:0] VEC_C = {1'b0, 1'b1, 16'h0F0F, 16'hF00F, 3'b110};
    localparam logic [36:0] ONES  = {1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 3'b111};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [36:0] e;
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, 16'h7777, 16'h8888, 3'b011);
        #2;
        chk("reset_state", w_obs, ZERO);
        @(posedge clk); #1;
        chk("reset_holds_edge", w_obs, ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b0);
        @(posedge clk); #1;
        chk("post_reset_load0", w_obs, ZERO);

        // normal capture
        drive(1'b1, 1'b1, 16'hABCD, 16'h1234, 3'b101);
        #3;
        chk("capture_before_edge", w_obs, ZERO);
        @(posedge clk); #1;
        chk("capture", w_obs, VEC_A);

        // async flush mid-cycle
        #1 flush = 1'b1;
        #1;
        chk("flush_async", w_obs, ZERO);
        drive(1'b1, 1'b0, 16'h5A5A, 16'hC3C3, 3'b010);
        @(posedge clk); #1;
        chk("flush_hold1", w_obs, ZERO);
        @(posedge clk); #1;
        chk("flush_hold2", w_obs, ZERO);
        #2 flush = 1'b0;
        #1;
        chk("flush_release_noedge", w_obs, ZERO);
        @(posedge clk); #1;
        chk("flush_release_load", w_obs, VEC_B);

        // async reset with nonzero contents
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async", w_obs, ZERO);
        drive(1'b0, 1'b1, 16'h0F0F, 16'hF00F, 3'b110);
        @(posedge clk); #1;
        chk("reset_hold", w_obs, ZERO);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_release_load", w_obs, VEC_C);

        // pipelined stream
        for (int i = 0; i < 8; i++) begin
            logic [15:0] a;
            logic [2:0]  w;
            a = 16'h0001 << i;
            w = 3'(i);
            drive(w[0], w[1], a, ~a, w);
            @(posedge clk); #1;
            e = {w[0], w[1], a, ~a, w};
            chk($sformatf("stream_%0d", i), w_obs, e);
        end

        // flush coinciding with a clock edge
        drive(1'b1, 1'b1, 16'hBEEF, 16'hCAFE, 3'b111);
        @(posedge clk);
        flush = 1'b1;
        #1;
        chk("flush_on_edge", w_obs, ZERO);
        #2 flush = 1'b0;

        // reset coinciding with a clock edge
        @(posedge clk); #1;
        chk("load_before_race", w_obs, {1'b1, 1'b1, 16'hBEEF, 16'hCAFE, 3'b111});
        drive(1'b0, 1'b1, 16'h1357, 16'h2468, 3'b001);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_on_edge", w_obs, ZERO);
        #2 rst_n = 1'b1;

        // width extremes
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 3'b111);
        @(posedge clk); #1;
        chk("all_ones", w_obs, ONES);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000);
        @(posedge clk); #1;
        chk("all_zeros", w_obs, ZERO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
